// File: rtl/servo_bank.sv
// Multi-channel servo PWM generator. All channels share one period counter.
// Each channel holds a target width (set by commands) and an applied width
// that follows the target once per period, optionally slew-limited.
module servo_bank #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CLK_HZ    = 98_304_000,
    parameter int unsigned PWM_HZ    = 50,
    parameter int unsigned POS_W     = 8,
    parameter int unsigned MIN_CYC   = 49_152,
    parameter int unsigned MAX_CYC   = 235_930,
    parameter int unsigned SLEW_CYC  = 0,
    parameter int unsigned RESET_POS = 0,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [CH_W-1:0]   cmd_ch_in,
    input  logic [POS_W-1:0]  cmd_pos_in,
    output logic              cmd_err_out,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] busy_out,
    output logic              frame_out
);

    localparam int unsigned PERIOD  = CLK_HZ / PWM_HZ;
    localparam int unsigned CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned WID_W   = $clog2(PERIOD + 1);
    localparam int unsigned POS_MAX = (1 << POS_W) - 1;
    localparam int unsigned STEP    = (MAX_CYC >= MIN_CYC) ? (MAX_CYC - MIN_CYC) / POS_MAX : 0;
    localparam int unsigned SLEW_CL = (SLEW_CYC > PERIOD) ? PERIOD : SLEW_CYC;

    localparam logic [WID_W-1:0] SLEW_W = WID_W'(SLEW_CL);

    // Elaboration-time parameter checks.
    if (MAX_CYC >= PERIOD) begin : g_bad_max
        $error("servo_bank: MAX_CYC must be smaller than the PWM period");
    end
    if (MIN_CYC > MAX_CYC) begin : g_bad_min
        $error("servo_bank: MIN_CYC must not exceed MAX_CYC");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("servo_bank: NUM_CH must be in 1..16");
    end
    if (POS_W < 1 || POS_W > 24) begin : g_bad_pos
        $error("servo_bank: POS_W out of supported range");
    end

    // Linear position-to-width map; full scale is pinned to MAX_CYC so the
    // truncated STEP never leaves the top position short.
    function automatic logic [WID_W-1:0] map_pos(input logic [POS_W-1:0] pos);
        logic [31:0] w;
        if (32'(pos) == POS_MAX) begin
            w = MAX_CYC;
        end else begin
            w = MIN_CYC + 32'(pos) * STEP;
        end
        return WID_W'(w);
    endfunction

    localparam logic [WID_W-1:0] RESET_W = map_pos(POS_W'(RESET_POS));

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_q, frame_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [WID_W-1:0]  target_q  [NUM_CH];
    logic [WID_W-1:0]  target_d  [NUM_CH];
    logic [WID_W-1:0]  applied_q [NUM_CH];
    logic [WID_W-1:0]  applied_d [NUM_CH];

    logic             cnt_last;
    logic             cmd_accept;
    logic             ch_valid;
    logic [WID_W-1:0] cmd_width;

    assign cnt_last   = (cnt_q == CNT_W'(PERIOD - 1));
    assign cmd_accept = cmd_valid_in && ready_q;
    assign ch_valid   = (32'(cmd_ch_in) < NUM_CH);
    assign cmd_width  = map_pos(cmd_pos_in);

    // Period counter, frame marker, handshake and error pulse.
    always_comb begin
        cnt_d   = cnt_last ? '0 : cnt_q + CNT_W'(1);
        frame_d = (cnt_q == '0);
        ready_d = 1'b1;
        err_d   = cmd_accept && !ch_valid;
    end

    // Target update from accepted commands; an out-of-range channel matches nothing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            target_d[i] = target_q[i];
            if (cmd_accept && (cmd_ch_in == CH_W'(i))) begin
                target_d[i] = cmd_width;
            end
        end
    end

    // Applied width moves only at the end of a period, using the pre-edge target.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            applied_d[i] = applied_q[i];
            if (cnt_last) begin
                if (SLEW_CYC == 0) begin
                    applied_d[i] = target_q[i];
                end else if (target_q[i] > applied_q[i]) begin
                    applied_d[i] = ((target_q[i] - applied_q[i]) > SLEW_W) ?
                                   applied_q[i] + SLEW_W : target_q[i];
                end else begin
                    applied_d[i] = ((applied_q[i] - target_q[i]) > SLEW_W) ?
                                   applied_q[i] - SLEW_W : target_q[i];
                end
            end
        end
    end

    // PWM compare and busy flags; busy reflects the state being loaded this edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i]  = (WID_W'(cnt_q) < applied_q[i]);
            busy_d[i] = (applied_d[i] != target_d[i]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q   <= '0;
            frame_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pwm_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i]  <= RESET_W;
                applied_q[i] <= RESET_W;
            end
        end else begin
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            pwm_q     <= pwm_d;
            busy_q    <= busy_d;
            target_q  <= target_d;
            applied_q <= applied_d;
        end
    end

    assign cmd_ready_out = ready_q;
    assign cmd_err_out   = err_q;
    assign pwm_out       = pwm_q;
    assign busy_out      = busy_q;
    assign frame_out     = frame_q;

endmodule

// File: doc/servo_bank.md
Name: servo_bank

Overview:
- Multi-channel servo PWM generator. Successor to the single-channel fixed-table servo driver.
- NUM_CH channels share one period counter, and each channel has its own target position.
- Position resolution is parametrised, and the pulse width is linearly mapped rather than table-driven.
- Optional per-period slew limiting lets servos ramp to new positions. Commands arrive over a valid/ready port from the control FSM.

Parameters:
- NUM_CH, 4: number of servo channels (1..16).
- CLK_HZ, 98_304_000: clk_in frequency.
- PWM_HZ, 50: PWM frame rate. PERIOD = CLK_HZ/PWM_HZ cycles (1_966_080 at defaults).
- POS_W, 8: position command width.
- MIN_CYC, 49_152: pulse width in cycles at position 0.
- MAX_CYC, 235_930: pulse width in cycles at position 2^POS_W-1.
- SLEW_CYC, 0: maximum change of applied width per period. 0 means jump to target immediately.
- RESET_POS, 0: position loaded into every channel on reset.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- cmd_valid_in, input, 1: command valid.
- cmd_ready_out, output, 1: command ready.
- cmd_ch_in, input, CH_W=max(1,$clog2(NUM_CH)): target channel index.
- cmd_pos_in, input, POS_W: target position.
- cmd_err_out, output, 1: one-cycle pulse when an accepted command has cmd_ch_in >= NUM_CH.
- pwm_out, output, NUM_CH: servo PWM lines.
- busy_out, output, NUM_CH: high while a channel's applied width differs from its target width.
- frame_out, output, 1: one-cycle pulse in the cycle every pwm_out rises (frame start).

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst_in. All state is registered.
- Reset values:
  - pwm_out=0, frame_out=0, cmd_ready_out=0, cmd_err_out=0, busy_out=0.
  - Period counter=0.
  - Every target and applied width = map(RESET_POS).
- cmd_ready_out is 1 from the first cycle after rst_in deasserts. It is never dropped otherwise.
- A command is accepted when cmd_valid_in && cmd_ready_out.
- Position-to-width mapping:
  - map(p) = MIN_CYC + p*STEP, with STEP = (MAX_CYC-MIN_CYC)/(2^POS_W-1) (integer truncation, localparam).
  - p = 2^POS_W-1 maps exactly to MAX_CYC.
  - Width registers are $clog2(PERIOD+1) bits.
  - Elaboration must fail if MAX_CYC >= PERIOD or MIN_CYC > MAX_CYC.
- Accepted command with valid channel: target[ch] <= map(pos) on the next edge. The multiply is by a constant, so no divider is needed.
- Accepted command with invalid channel: no state change, and cmd_err_out=1 for exactly one cycle.
- Back-to-back commands to the same channel: the last one wins.
- Period counter counts 0..PERIOD-1, then wraps to 0.
- Applied-width update occurs only on the edge where counter==PERIOD-1, so there are never mid-pulse changes:
  - SLEW_CYC=0: applied <= target.
  - Otherwise applied moves toward target by min(SLEW_CYC, |target-applied|).
  - The update uses the target value held before that edge. A command accepted in the counter==PERIOD-1 cycle takes effect one period later.
- pwm_out[i] is registered: pwm_out[i] <= (counter < applied[i]).
  - The high time is exactly applied[i] cycles per period.
  - The rising edge is one cycle after counter==0.
- frame_out <= (counter==0), aligned with the pwm rising edge.
- busy_out[i] = (applied[i] != target[i]), registered.
- Reset asserted mid-pulse: pwm_out drops on the next edge. All widths return to map(RESET_POS). The frame restarts from counter 0 after release.

Test Plan:
Bench params for all scenarios: CLK_HZ=1000, PWM_HZ=10 (PERIOD=100), NUM_CH=3, POS_W=2, MIN_CYC=10, MAX_CYC=40 (STEP=10), RESET_POS=0.
- Reset: hold rst_in 3 cycles -> pwm_out=000 and ready=0 during reset. After release, ready=1 next cycle. Each channel is high exactly 10 cycles per 100, and frame_out pulses every 100 cycles coincident with pwm rises.
- Immediate update (SLEW_CYC=0): cmd ch1 pos3 at counter 40 -> current frame unchanged. From the next frame, ch1 is high 40 cycles and ch0/ch2 stay at 10.
- Slew (SLEW_CYC=5): cmd ch0 pos3 -> successive frames show ch0 widths 15,20,25,30,35,40. busy_out[0] is high until the 40-cycle frame is applied, then 0. Then cmd pos1 -> 35,30,25,20.
- Boundary timing: cmd ch2 pos2 in the counter==99 cycle -> next frame still 10, the frame after is 30. Two consecutive cmds ch2 pos1 then pos3 -> 40 applied.
- Invalid channel: cmd ch3 pos2 -> cmd_err_out high exactly one cycle, all widths unchanged, ready stays 1.
- Reset mid-operation: with ch1 at 40, assert rst_in at counter 20 -> pwm_out[1]=0 next edge. After release, ch1 width is 10 and the counter restarts at 0.
